// File: rtl/laser_pkg.sv
// Shared constants and state encoding for the LASER coverage-count engine.
package laser_pkg;

  localparam int COORD_W = 4;
  localparam int NUM_TGT = 40;
  localparam int RADIUS  = 4;
  localparam int R_SQ    = RADIUS * RADIUS;
  localparam int ADDR_W  = 6;
  localparam int SUM_W   = 2 * COORD_W + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TGT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/laser_in_circle.sv
// Combinational test: is point (px,py) within RADIUS of centre (cx,cy), boundary included.
module laser_in_circle
  import laser_pkg::*;
(
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  output logic               o_inside
);

  logic [COORD_W-1:0]   w_dx;
  logic [COORD_W-1:0]   w_dy;
  logic [2*COORD_W-1:0] w_dx_ext;
  logic [2*COORD_W-1:0] w_dy_ext;
  logic [2*COORD_W-1:0] w_sq_x;
  logic [2*COORD_W-1:0] w_sq_y;
  logic [SUM_W-1:0]     w_sum;

  // Subtract the smaller from the larger so the difference never wraps.
  assign w_dx = (i_px >= i_cx) ? (i_px - i_cx) : (i_cx - i_px);
  assign w_dy = (i_py >= i_cy) ? (i_py - i_cy) : (i_cy - i_py);

  assign w_dx_ext = {{COORD_W{1'b0}}, w_dx};
  assign w_dy_ext = {{COORD_W{1'b0}}, w_dy};
  assign w_sq_x   = w_dx_ext * w_dx_ext;
  assign w_sq_y   = w_dy_ext * w_dy_ext;
  assign w_sum    = {1'b0, w_sq_x} + {1'b0, w_sq_y};

  assign o_inside = (w_sum <= SUM_W'(R_SQ));

endmodule

// File: rtl/laser_cover_count.sv
// Scans the stored target list once per start and counts targets inside the candidate
// circle, optionally skipping those inside an excluded circle.
//
// state | meaning
// IDLE  | waiting for start, tgt_addr held at 0
// SCAN  | one target per cycle, result published on the last address
module laser_cover_count
  import laser_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [COORD_W-1:0] cand_x,
  input  logic [COORD_W-1:0] cand_y,
  input  logic               excl_en,
  input  logic [COORD_W-1:0] excl_x,
  input  logic [COORD_W-1:0] excl_y,
  output logic [ADDR_W-1:0]  tgt_addr,
  input  logic [COORD_W-1:0] tgt_x,
  input  logic [COORD_W-1:0] tgt_y,
  output logic               busy,
  output logic [ADDR_W-1:0]  count,
  output logic               valid
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_acc;
  logic [ADDR_W-1:0]  r_count;
  logic               r_valid;
  logic [COORD_W-1:0] r_cand_x;
  logic [COORD_W-1:0] r_cand_y;
  logic               r_excl_en;
  logic [COORD_W-1:0] r_excl_x;
  logic [COORD_W-1:0] r_excl_y;

  logic w_in_cand;
  logic w_in_excl;
  logic w_hit;
  logic w_busy;
  logic w_accept;
  logic w_last;

  laser_in_circle u_cand (
    .i_px     (tgt_x),
    .i_py     (tgt_y),
    .i_cx     (r_cand_x),
    .i_cy     (r_cand_y),
    .o_inside (w_in_cand)
  );

  laser_in_circle u_excl (
    .i_px     (tgt_x),
    .i_py     (tgt_y),
    .i_cx     (r_excl_x),
    .i_cy     (r_excl_y),
    .o_inside (w_in_excl)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = SCAN;
      SCAN:    if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state == SCAN);
    w_accept = (r_state == IDLE) && start;
    w_last   = (r_state == SCAN) && (r_addr == LAST_ADDR);
    w_hit    = w_in_cand & ~(r_excl_en & w_in_excl);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr    <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_cand_x  <= '0;
      r_cand_y  <= '0;
      r_excl_en <= 1'b0;
      r_excl_x  <= '0;
      r_excl_y  <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_cand_x  <= cand_x;
        r_cand_y  <= cand_y;
        r_excl_en <= excl_en;
        r_excl_x  <= excl_x;
        r_excl_y  <= excl_y;
        r_addr    <= '0;
        r_acc     <= '0;
      end else if (w_last) begin
        // The last target's hit is folded in directly rather than via the accumulator.
        r_count <= r_acc + {{(ADDR_W-1){1'b0}}, w_hit};
        r_valid <= 1'b1;
        r_addr  <= '0;
      end else if (w_busy) begin
        r_acc  <= r_acc + {{(ADDR_W-1){1'b0}}, w_hit};
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign tgt_addr = r_addr;
  assign busy     = w_busy;
  assign count    = r_count;
  assign valid    = r_valid;

endmodule

// File: tb/tb_laser_cover_count.sv
// Scoreboard bench for laser_cover_count: directed cases plus randomized evaluations
// checked against a distance-formula reference model.
module tb_laser_cover_count;

  logic       CLK;
  logic       RST;
  logic       start;
  logic [3:0] cand_x, cand_y, excl_x, excl_y;
  logic       excl_en;
  logic [5:0] tgt_addr;
  logic [3:0] tgt_x, tgt_y;
  logic       busy;
  logic [5:0] count;
  logic       valid;

  logic [3:0] mem_x [64];
  logic [3:0] mem_y [64];

  typedef struct {
    int cnt;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  assign tgt_x = mem_x[tgt_addr];
  assign tgt_y = mem_y[tgt_addr];

  laser_cover_count dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .cand_x   (cand_x),
    .cand_y   (cand_y),
    .excl_en  (excl_en),
    .excl_x   (excl_x),
    .excl_y   (excl_y),
    .tgt_addr (tgt_addr),
    .tgt_x    (tgt_x),
    .tgt_y    (tgt_y),
    .busy     (busy),
    .count    (count),
    .valid    (valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference: count targets within Euclidean radius 4, minus those inside the excluded circle.
  function automatic int model(int cx, int cy, int en, int ex, int ey);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      int tx = int'(mem_x[i]);
      int ty = int'(mem_y[i]);
      bit in_c = ((tx-cx)*(tx-cx) + (ty-cy)*(ty-cy)) <= 16;
      bit in_e = ((tx-ex)*(tx-ex) + (ty-ey)*(ty-ey)) <= 16;
      if (in_c && !(en != 0 && in_e)) n++;
    end
    return n;
  endfunction

  always @(negedge CLK) begin
    if (valid) begin
      if (sbq.size() == 0) begin
        check("valid_unexpected", int'(valid), 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("count", int'(count), e.cnt);
        check("latency", cyc, e.due);
        check("addr_on_valid", int'(tgt_addr), 0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill(int x, int y);
    for (int i = 0; i < 64; i++) begin
      mem_x[i] = 4'(x);
      mem_y[i] = 4'(y);
    end
  endtask

  task automatic issue(int cx, int cy, int en, int ex, int ey);
    exp_t e;
    cand_x  = 4'(cx);
    cand_y  = 4'(cy);
    excl_en = (en != 0);
    excl_x  = 4'(ex);
    excl_y  = 4'(ey);
    start   = 1'b1;
    e.cnt   = model(cx, cy, en, ex, ey);
    e.due   = cyc + 41;
    sbq.push_back(e);
    tick();
    start = 1'b0;
  endtask

  // Returns on the cycle where valid is visible, so a following issue is back-to-back.
  task automatic wait_done(int exp_busy);
    int nb = 0;
    int n  = 0;
    while (!valid && n < 60) begin
      if (busy) nb++;
      tick();
      n++;
    end
    check("done_in_time", int'(valid), 1);
    check("busy_cycles", nb, exp_busy);
    check("busy_low_on_valid", int'(busy), 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    RST      = 1'b1;
    start    = 1'b0;
    cand_x   = '0;
    cand_y   = '0;
    excl_en  = 1'b0;
    excl_x   = '0;
    excl_y   = '0;
    fill(0, 0);

    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_addr", int'(tgt_addr), 0);
    RST = 1'b0;
    tick();

    // single hit at the centre, everything else far away
    fill(0, 0);
    mem_x[0] = 4'd8; mem_y[0] = 4'd8;
    issue(8, 8, 0, 0, 0);
    wait_done(40);

    // exactly on the boundary, then just outside it
    fill(4, 4);
    tick();
    issue(0, 4, 0, 0, 0);
    wait_done(40);
    issue(0, 3, 0, 0, 0);
    wait_done(40);

    // corner centre: no wrap on the absolute difference
    fill(7, 7);
    mem_x[0] = 4'd0;  mem_y[0] = 4'd0;
    mem_x[1] = 4'd15; mem_y[1] = 4'd15;
    tick();
    issue(15, 15, 0, 0, 0);
    wait_done(40);

    // exclusion overlapping, far away, and identical to the candidate
    fill(5, 5);
    tick();
    issue(5, 5, 1, 6, 6);
    wait_done(40);
    issue(5, 5, 1, 12, 12);
    wait_done(40);
    issue(5, 5, 1, 5, 5);
    wait_done(40);

    // start while busy is ignored; a start on the valid cycle is accepted
    for (int i = 0; i < 10; i++) begin
      mem_x[i] = 4'd0;
      mem_y[i] = 4'd0;
    end
    tick();
    issue(5, 5, 0, 0, 0);
    repeat (9) tick();
    cand_x = 4'd0; cand_y = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(30);
    issue(0, 0, 0, 0, 0);
    wait_done(40);

    // reset mid-scan aborts without a result
    tick();
    issue(5, 5, 0, 0, 0);
    repeat (19) tick();
    RST = 1'b1;
    sbq.delete();
    tick();
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_addr", int'(tgt_addr), 0);
    RST = 1'b0;
    repeat (45) tick();
    issue(5, 5, 0, 0, 0);
    wait_done(40);

    // randomized evaluations, targets clustered so counts span the full range
    for (int r = 0; r < 25; r++) begin
      int bx = $urandom_range(15);
      int by = $urandom_range(15);
      int spread = $urandom_range(1, 15);
      for (int i = 0; i < 40; i++) begin
        int x = bx + $urandom_range(spread) - spread / 2;
        int y = by + $urandom_range(spread) - spread / 2;
        mem_x[i] = 4'((x < 0) ? 0 : (x > 15) ? 15 : x);
        mem_y[i] = 4'((y < 0) ? 0 : (y > 15) ? 15 : y);
      end
      repeat ($urandom_range(1, 3)) tick();
      issue($urandom_range(15), $urandom_range(15), $urandom_range(1),
            $urandom_range(15), $urandom_range(15));
      wait_done(40);
    end

    repeat (5) tick();
    check("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
